// File: rtl/line_buffer_maxpool_2x2_pkg.sv
// rtl/line_buffer_maxpool_2x2_pkg.sv - shared sample types and signed max helper
package line_buffer_maxpool_2x2_pkg;

    localparam int WORDLENGTH = 16;
    localparam int MAX_WIDTH  = 64;

    typedef logic signed [WORDLENGTH-1:0] sample_t;
    typedef logic signed [MAX_WIDTH-1:0]  wide_sample_t;

    // Callers sign-extend into the wide type so any sample width up to MAX_WIDTH works.
    function automatic wide_sample_t max2(input wide_sample_t a, input wide_sample_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/line_buffer_maxpool_2x2_line_buffer_2row.sv
// rtl/line_buffer_maxpool_2x2_line_buffer_2row.sv - two-row line buffer with column/parity tracking
module line_buffer_2row
    import line_buffer_maxpool_2x2_pkg::*;
#(
    parameter int dataColNum = 28,
    parameter int col_length = 5,
    parameter int wordlength = WORDLENGTH
) (
    input  logic                         clk,
    input  logic                         irst_n,
    input  logic                         in_valid,
    input  logic signed [wordlength-1:0] data_in,
    output logic signed [wordlength-1:0] pixels_0,
    output logic signed [wordlength-1:0] pixels_1,
    output logic                         lb_valid,
    output logic        [col_length-1:0] col,
    output logic                         odd_row
);

    localparam logic [col_length-1:0] LAST_COL = col_length'(dataColNum - 1);

    logic signed [wordlength-1:0] taps_q [dataColNum];
    logic signed [wordlength-1:0] pixels_0_q;
    logic signed [wordlength-1:0] pixels_1_q;
    logic        [col_length-1:0] cnt_q;
    logic        [col_length-1:0] cnt_d;
    logic        [col_length-1:0] col_q;
    logic                         par_q;
    logic                         par_d;
    logic                         filled_q;
    logic                         filled_d;
    logic                         odd_q;
    logic                         lb_valid_q;

    // cnt_q/par_q describe the next sample to arrive; col_q/odd_q describe the registered pixels.
    always_comb begin
        cnt_d    = cnt_q;
        par_d    = par_q;
        filled_d = filled_q;
        if (in_valid) begin
            if (cnt_q == LAST_COL) begin
                cnt_d    = '0;
                par_d    = ~par_q;
                filled_d = 1'b1;
            end else begin
                cnt_d = cnt_q + col_length'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge irst_n) begin
        if (!irst_n) begin
            for (int i = 0; i < dataColNum; i++) begin
                taps_q[i] <= '0;
            end
            pixels_0_q <= '0;
            pixels_1_q <= '0;
            cnt_q      <= '0;
            col_q      <= '0;
            par_q      <= 1'b0;
            odd_q      <= 1'b0;
            filled_q   <= 1'b0;
            lb_valid_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            par_q      <= par_d;
            filled_q   <= filled_d;
            lb_valid_q <= in_valid & filled_q;
            if (in_valid) begin
                taps_q[0] <= data_in;
                for (int i = 1; i < dataColNum; i++) begin
                    taps_q[i] <= taps_q[i-1];
                end
                pixels_0_q <= data_in;
                pixels_1_q <= taps_q[dataColNum-1];
                col_q      <= cnt_q;
                odd_q      <= par_q;
            end
        end
    end

    assign pixels_0 = pixels_0_q;
    assign pixels_1 = pixels_1_q;
    assign lb_valid = lb_valid_q;
    assign col      = col_q;
    assign odd_row  = odd_q;

endmodule

// File: rtl/line_buffer_maxpool_2x2.sv
// rtl/line_buffer_maxpool_2x2.sv - streaming 2x2 stride-2 signed max-pooling stage
module line_buffer_maxpool_2x2
    import line_buffer_maxpool_2x2_pkg::*;
#(
    parameter int dataColNum = 28,
    parameter int col_length = 5,
    parameter int wordlength = WORDLENGTH
) (
    input  logic                         clk,
    input  logic                         irst_n,
    input  logic                         in_valid,
    input  logic signed [wordlength-1:0] data_in,
    output logic signed [wordlength-1:0] data_out,
    output logic                         out_valid
);

    localparam logic [col_length-1:0] LAST_COL = col_length'(dataColNum - 1);

    logic signed [wordlength-1:0] pix0;
    logic signed [wordlength-1:0] pix1;
    logic                         lb_valid;
    logic        [col_length-1:0] col;
    logic                         odd_row;

    logic signed [wordlength-1:0] pair_max;
    logic signed [wordlength-1:0] quad_max;
    logic signed [wordlength-1:0] hold_q;
    logic signed [wordlength-1:0] hold_d;
    logic signed [wordlength-1:0] data_out_q;
    logic signed [wordlength-1:0] data_out_d;
    logic                         out_valid_q;
    logic                         out_valid_d;

    line_buffer_2row #(
        .dataColNum (dataColNum),
        .col_length (col_length),
        .wordlength (wordlength)
    ) u_line_buffer (
        .clk      (clk),
        .irst_n   (irst_n),
        .in_valid (in_valid),
        .data_in  (data_in),
        .pixels_0 (pix0),
        .pixels_1 (pix1),
        .lb_valid (lb_valid),
        .col      (col),
        .odd_row  (odd_row)
    );

    always_comb begin
        pair_max    = wordlength'(max2(wide_sample_t'(pix0), wide_sample_t'(pix1)));
        quad_max    = wordlength'(max2(wide_sample_t'(hold_q), wide_sample_t'(pair_max)));
        hold_d      = hold_q;
        data_out_d  = data_out_q;
        out_valid_d = 1'b0;
        if (lb_valid && odd_row) begin
            if (col[0]) begin
                data_out_d  = quad_max;
                out_valid_d = 1'b1;
            end else if (col != LAST_COL) begin
                // The trailing column of an odd-width row has no partner and is never pooled.
                hold_d = pair_max;
            end
        end
    end

    always_ff @(posedge clk or negedge irst_n) begin
        if (!irst_n) begin
            hold_q      <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_line_buffer_maxpool_2x2.sv
// tb/tb_line_buffer_maxpool_2x2.sv - scoreboard bench for the 2x2 max-pool stage
module tb_line_buffer_maxpool_2x2;

    typedef struct {
        int val;
        int edge_n;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_a, rst_b, va, vb, ova, ovb;
    logic signed [15:0] da, db, oa, ob;

    always #5 clk = ~clk;

    line_buffer_maxpool_2x2 dut_a (
        .clk (clk), .irst_n (rst_a), .in_valid (va), .data_in (da),
        .data_out (oa), .out_valid (ova)
    );

    line_buffer_maxpool_2x2 #(.dataColNum(5), .col_length(3), .wordlength(16)) dut_b (
        .clk (clk), .irst_n (rst_b), .in_valid (vb), .data_in (db),
        .data_out (ob), .out_valid (ovb)
    );

    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t xa, xb;
    int   a_log[$];
    int   b_log[$];
    int   ramp_ref[$];
    int   last_a = 0;
    int   last_b = 0;

    int prev_row [2][32];
    int cur_row  [2][32];
    int mcol     [2];
    int modd     [2];
    int ncol     [2] = '{28, 5};

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check_val(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_reset(input int u);
        mcol[u] = 0;
        modd[u] = 0;
    endtask

    task automatic model_accept(input int u, input int v);
        int   c;
        exp_t e;
        c = mcol[u];
        cur_row[u][c] = v;
        if (modd[u] == 1 && (c % 2) == 1) begin
            e.val    = imax(imax(v, prev_row[u][c]), imax(cur_row[u][c-1], prev_row[u][c-1]));
            e.edge_n = edge_cnt + 2;
            if (u == 0) qa.push_back(e);
            else        qb.push_back(e);
        end
        if (c == ncol[u] - 1) begin
            mcol[u] = 0;
            modd[u] = 1 - modd[u];
            for (int i = 0; i < 32; i++) prev_row[u][i] = cur_row[u][i];
        end else begin
            mcol[u] = c + 1;
        end
    endtask

    task automatic drive(input int u, input bit v, input int d);
        @(negedge clk);
        if (u == 0) begin va = v; da = 16'(d); end
        else        begin vb = v; db = 16'(d); end
        if (v) model_accept(u, d);
    endtask

    task automatic reset_a();
        @(negedge clk);
        va = 1'b0;
        #2 rst_a = 1'b0;
        #1;
        check_val("rst_data_now", oa, 0);
        check_val("rst_valid_now", ova, 0);
        qa.delete();
        model_reset(0);
        last_a = 0;
        repeat (2) begin
            @(negedge clk);
            check_val("rst_valid_held", ova, 0);
        end
        rst_a = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_a) begin
            if (qa.size() > 0 && qa[0].edge_n < edge_cnt) begin
                check_val("a_missing", 0, qa[0].val);
                void'(qa.pop_front());
            end
            if (ova) begin
                if (qa.size() == 0) begin
                    check_val("a_spurious", ova, 0);
                end else begin
                    xa = qa.pop_front();
                    check_val("a_data", oa, xa.val);
                    check_val("a_latency", edge_cnt, xa.edge_n);
                end
                a_log.push_back(int'(oa));
                last_a = int'(oa);
            end else begin
                check_val("a_hold", oa, last_a);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_b) begin
            if (qb.size() > 0 && qb[0].edge_n < edge_cnt) begin
                check_val("b_missing", 0, qb[0].val);
                void'(qb.pop_front());
            end
            if (ovb) begin
                if (qb.size() == 0) begin
                    check_val("b_spurious", ovb, 0);
                end else begin
                    xb = qb.pop_front();
                    check_val("b_data", ob, xb.val);
                    check_val("b_latency", edge_cnt, xb.edge_n);
                end
                b_log.push_back(int'(ob));
                last_b = int'(ob);
            end else begin
                check_val("b_hold", ob, last_b);
            end
        end
    end

    initial begin
        int c;
        int sig_rows [20];
        rst_a = 1'b0; rst_b = 1'b0; va = 1'b0; vb = 1'b0; da = '0; db = '0;
        model_reset(0);
        model_reset(1);
        #1;
        check_val("init_a_data", oa, 0);
        check_val("init_a_valid", ova, 0);
        check_val("init_b_data", ob, 0);
        check_val("init_b_valid", ovb, 0);
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;

        for (int v = 1; v <= 1024; v++) drive(0, 1'b1, v);
        drive(0, 1'b0, 0);
        repeat (4) @(negedge clk);
        check_val("ramp_count", a_log.size(), 252);
        if (a_log.size() == 252) begin
            check_val("ramp_first", a_log[0], 30);
            check_val("ramp_row1_last", a_log[13], 56);
            check_val("ramp_row3_first", a_log[14], 86);
            check_val("ramp_last", a_log[251], 1008);
        end
        ramp_ref = a_log;

        reset_a();
        a_log.delete();
        c = 0;
        for (int v = 1; v <= 1024; v++) begin
            if (c % 3 == 2) begin
                drive(0, 1'b0, 0);
                c++;
            end
            drive(0, 1'b1, v);
            c++;
        end
        drive(0, 1'b0, 0);
        repeat (4) @(negedge clk);
        check_val("stall_count", a_log.size(), ramp_ref.size());
        for (int i = 0; i < a_log.size() && i < ramp_ref.size(); i++) begin
            check_val("stall_seq", a_log[i], ramp_ref[i]);
        end

        reset_a();
        for (int v = 1; v <= 40; v++) drive(0, 1'b1, v);
        reset_a();
        a_log.delete();
        for (int v = 1; v <= 60; v++) drive(0, 1'b1, v);
        drive(0, 1'b0, 0);
        repeat (4) @(negedge clk);
        check_val("rst_first_out", (a_log.size() > 0) ? a_log[0] : -1, 30);

        b_log.delete();
        for (int v = 1; v <= 20; v++) drive(1, 1'b1, v);
        drive(1, 1'b0, 0);
        repeat (4) @(negedge clk);
        check_val("odd_count", b_log.size(), 4);
        check_val("odd_out0", (b_log.size() > 0) ? b_log[0] : -1, 7);
        check_val("odd_out1", (b_log.size() > 1) ? b_log[1] : -1, 9);
        check_val("odd_out2", (b_log.size() > 2) ? b_log[2] : -1, 17);
        check_val("odd_out3", (b_log.size() > 3) ? b_log[3] : -1, 19);

        sig_rows = '{-5, -3, 0, 0, 0,
                     -7, -2, 0, 0, 0,
                     -32768, 32767, 0, 0, 0,
                     0, -1, 0, 0, 0};
        b_log.delete();
        for (int i = 0; i < 20; i++) drive(1, 1'b1, sig_rows[i]);
        drive(1, 1'b0, 0);
        repeat (4) @(negedge clk);
        check_val("signed_count", b_log.size(), 4);
        check_val("signed_neg", (b_log.size() > 0) ? b_log[0] : 99, -2);
        check_val("signed_extreme", (b_log.size() > 2) ? b_log[2] : 99, 32767);

        check_val("qa_drained", qa.size(), 0);
        check_val("qb_drained", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
